// File: rtl/mult_div_if.sv
// Request/result bundle between a requester and the HI/LO multiply-divide unit.
interface mult_div_if;
  logic        start;
  logic [5:0]  fncode;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, fncode, op_a, op_b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, fncode, op_a, op_b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with MTHI/MTLO, 33-cycle latency.
// One shift-add or restoring shift-subtract step per cycle on magnitudes; signs fixed up at the end.
module mult_div_unit (
  input  logic       clk,
  input  logic       reset,
  mult_div_if.slave  bus
);

  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] a_raw_q, a_raw_d;
  logic        is_div_q, is_div_d;
  logic        neg_q_q, neg_q_d;
  logic        neg_r_q, neg_r_d;
  logic        div0_q, div0_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [32:0] mul_sum_s;
  logic [64:0] shl_s;
  logic [32:0] trial_s;
  logic        is_signed_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [63:0] prod_s;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
    return neg ? (64'd0 - v) : v;
  endfunction

  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      a_raw_q  <= 32'd0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      a_raw_q  <= a_raw_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      div0_q   <= div0_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Multiply keeps the product high half in acc[63:32] with the multiplier shifting out of acc[31:0];
  // divide keeps the partial remainder in acc[63:32] and shifts quotient bits into acc[31:0].
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    a_raw_d  = a_raw_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    div0_d   = div0_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    is_signed_s = ~bus.fncode[0];
    a_mag_s     = mag32(bus.op_a, is_signed_s);
    b_mag_s     = mag32(bus.op_b, is_signed_s);
    mul_sum_s   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    shl_s       = {acc_q, 1'b0};
    trial_s     = shl_s[64:32] - {1'b0, opnd_q};
    prod_s      = cond_neg64(acc_q, neg_q_q);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.fncode)
            FN_MTHI: begin
              hi_d   = bus.op_a;
              done_d = 1'b1;
            end
            FN_MTLO: begin
              lo_d   = bus.op_a;
              done_d = 1'b1;
            end
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
              is_div_d = bus.fncode[1];
              neg_q_d  = is_signed_s & (bus.op_a[31] ^ bus.op_b[31]);
              neg_r_d  = is_signed_s & bus.op_a[31];
              div0_d   = (bus.op_b == 32'd0);
              a_raw_d  = bus.op_a;
              cnt_d    = 5'd0;
              busy_d   = 1'b1;
              state_d  = S_RUN;
              if (bus.fncode[1]) begin
                acc_d  = {32'd0, a_mag_s};
                opnd_d = b_mag_s;
              end else begin
                acc_d  = {32'd0, b_mag_s};
                opnd_d = a_mag_s;
              end
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          if (!trial_s[32]) begin
            acc_d = {trial_s[31:0], shl_s[31:1], 1'b1};
          end else begin
            acc_d = shl_s[63:0];
          end
        end else begin
          acc_d = {mul_sum_s, acc_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIX;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIX: begin
        if (is_div_q) begin
          if (div0_q) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = a_raw_q;
          end else begin
            lo_d = cond_neg32(acc_q[31:0], neg_q_q);
            hi_d = cond_neg32(acc_q[63:32], neg_r_q);
          end
        end else begin
          hi_d = prod_s[63:32];
          lo_d = prod_s[31:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request strobe, sampled on each rising edge.
REQ-005 fncode  input  6  ALU function code selecting the operation.
REQ-006 op_a  input  32  rs operand: multiplicand, dividend, or MTHI/MTLO source.
REQ-007 op_b  input  32  rt operand: multiplier or divisor.
REQ-008 busy  output  1  high while a multiply or divide is in progress.
REQ-009 done  output  1  registered one-cycle completion pulse.
REQ-010 hi  output  32  HI register, driven directly from the flop.
REQ-011 lo  output  32  LO register, driven directly from the flop.

Function
REQ-012 Accepted fncodes SHALL be:
- MTHI 6'h11
- MTLO 6'h13
- MULT 6'h18
- MULTU 6'h19
- DIV 6'h1A
- DIVU 6'h1B
REQ-013 Any other fncode with start=1 SHALL be ignored: no state change, no done, no busy.
REQ-014 The state machine SHALL have three states:
- IDLE
- RUN: 32 iterations, 5-bit counter
- FIX: sign correction and result write
REQ-015 Accept edge: start=1 in IDLE with MULT/MULTU/DIV/DIVU.
- The unit SHALL latch the operands, take magnitudes for signed ops, and record the result signs.
- It SHALL clear the counter, enter RUN and set busy=1.
REQ-016 RUN SHALL perform one iteration per edge: shift-add for multiply, restoring shift-subtract for divide.
REQ-017 RUN SHALL move to FIX on the edge that completes the 32nd iteration, i.e. the edge where counter==31.
REQ-018 On the FIX edge the unit SHALL:
- apply sign correction;
- write hi/lo;
- set done=1 and busy=0;
- return to IDLE.
REQ-019 Latency: busy SHALL be high for exactly 33 cycles after the accept edge. done and the new hi/lo SHALL appear together after the 33rd edge following the accept edge.
REQ-020 MTHI/MTLO accepted in IDLE SHALL write op_a to hi (resp. lo) on the accept edge. done=1 the next cycle; busy stays 0; the other register is unchanged.
REQ-021 start while busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-022 start SHALL be accepted in the same cycle that done=1, since the state is IDLE.
REQ-023 hi/lo SHALL hold their previous values during RUN; intermediate values SHALL never be visible.
REQ-024 done SHALL be a one-cycle pulse, low in every cycle not immediately following a FIX or MTHI/MTLO edge.
REQ-025 Multiply results:
- MULT: {hi,lo} = signed 64-bit product.
- MULTU: {hi,lo} = unsigned 64-bit product.
REQ-026 DIV SHALL produce lo = quotient truncated toward zero and hi = remainder carrying the dividend's sign.
REQ-027 DIVU SHALL produce lo = unsigned quotient and hi = unsigned remainder.
REQ-028 Divide by zero (DIV or DIVU) SHALL run the full latency and yield lo=32'hFFFF_FFFF, hi=op_a.
REQ-029 DIV 32'h8000_0000 / 32'hFFFF_FFFF SHALL yield lo=32'h8000_0000, hi=0.
REQ-030 Operands SHALL be captured at accept; changes to op_a, op_b or fncode during RUN SHALL NOT affect the result.

Reset
REQ-031 While reset=1 at an edge, the unit SHALL go to IDLE with busy=0, done=0, hi=0, lo=0, and the counter and datapath cleared.
REQ-032 Reset SHALL take priority over start, including a start in the same cycle.
REQ-033 Reset asserted during RUN or FIX SHALL abort the operation; no done SHALL follow the reset.
REQ-034 The first start after reset deasserts SHALL be accepted normally.

Verification
REQ-035 MULTU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> after 33 edges hi=32'hFFFF_FFFE, lo=32'h0000_0001, done=1 for exactly one cycle; busy high for 33 cycles.
REQ-036 MULT -3 x 7 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB; DIV -7 / 2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
REQ-037 DIVU 100 / 0 -> lo=32'hFFFF_FFFF, hi=100. DIV 32'h8000_0000 / -1 -> lo=32'h8000_0000, hi=0.
REQ-038 MTHI 32'hDEAD_BEEF, then MTLO 32'h1234_5678 on consecutive cycles -> both written, done pulses on two consecutive cycles, busy never high.
REQ-039 DIVU 1000/3 started, start with MULT issued at count 10, reset at count 20 -> MULT ignored; after reset hi=lo=0, busy=0, no done pulse; a following DIVU 10/3 gives lo=3, hi=1.
